// File: rtl/fruit_spawn_ctrl.sv
// fruit_spawn_ctrl
// Sequencer that picks the next fruit position. On a spawn request it walks
// the fruit-position table starting at the current address, decodes each
// entry, skips out-of-range cells and cells the occupancy checker reports as
// taken, and commits the first free cell as the live fruit. If a full lap of
// the table yields nothing, the attempt ends with the sticky spawn_fail flag.
module fruit_spawn_ctrl #(
  parameter int TABLE_DEPTH = 31,
  parameter int MAX_ROW     = 14,
  parameter int MAX_COL     = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spawn_req,
  input  logic        fruit_clear,
  output logic        tbl_rst,
  output logic [4:0]  fruit_addr,
  input  logic [31:0] fruit_next,
  output logic        occ_req,
  output logic [3:0]  occ_row,
  output logic [4:0]  occ_col,
  input  logic        occ_ack,
  input  logic        occ_hit,
  output logic        busy,
  output logic        fruit_valid,
  output logic [3:0]  fruit_row,
  output logic [4:0]  fruit_col,
  output logic        spawn_done,
  output logic        spawn_fail
);

  // Constants sized to the registers they are compared against.
  localparam logic [4:0] LAST_ADDR = 5'(TABLE_DEPTH - 1);
  localparam logic [5:0] TRIES_MAX = 6'(TABLE_DEPTH);
  localparam logic [3:0] TMO_LAST  = 4'(ACK_TIMEOUT - 1);
  localparam logic [3:0] ROW_LIMIT = 4'(MAX_ROW);
  localparam logic [4:0] COL_LIMIT = 5'(MAX_COL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_QUERY   = 3'd2,
    S_ADVANCE = 3'd3,
    S_COMMIT  = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t      state_r;
  logic [5:0]  tries_r;
  logic [3:0]  tmo_r;
  logic [3:0]  cand_row_r;
  logic [4:0]  cand_col_r;

  logic [9:0]  fetch_pos_s;
  logic        fetch_bad_s;
  logic [4:0]  addr_inc_s;

  // Next table address, wrapping from the last entry back to entry 0.
  function automatic logic [4:0] wrap_inc(input logic [4:0] addr);
    if (addr == LAST_ADDR) begin
      return 5'd0;
    end else begin
      return addr + 5'd1;
    end
  endfunction

  // A table word is unusable when the pad bit is set or row/col exceed the board.
  function automatic logic cand_bad(input logic [9:0] pos);
    logic bad;
    bad = 1'b0;
    if (pos[9] == 1'b1) begin
      bad = 1'b1;
    end else if (pos[8:5] > ROW_LIMIT) begin
      bad = 1'b1;
    end else if (pos[4:0] > COL_LIMIT) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // Decode the word currently presented by the table and the wrapped address.
  always_comb begin
    fetch_pos_s = fruit_next[13:4];
    fetch_bad_s = cand_bad(fruit_next[13:4]);
    addr_inc_s  = wrap_inc(fruit_addr);
  end

  // Table init follows reset by one edge so the table comes out of init with us.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tbl_rst <= 1'b1;
    end else begin
      tbl_rst <= 1'b0;
    end
  end

  // Spawn sequencer: state, table walk, occupancy handshake and fruit outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      fruit_addr  <= 5'd0;
      tries_r     <= 6'd0;
      tmo_r       <= 4'd0;
      cand_row_r  <= 4'd0;
      cand_col_r  <= 5'd0;
      occ_req     <= 1'b0;
      occ_row     <= 4'd0;
      occ_col     <= 5'd0;
      busy        <= 1'b0;
      fruit_valid <= 1'b0;
      fruit_row   <= 4'd0;
      fruit_col   <= 5'd0;
      spawn_done  <= 1'b0;
      spawn_fail  <= 1'b0;
    end else begin
      // spawn_done is a single-cycle pulse unless COMMIT/FAIL re-arms it.
      spawn_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (spawn_req) begin
            fruit_valid <= 1'b0;
            spawn_fail  <= 1'b0;
            tries_r     <= 6'd0;
            busy        <= 1'b1;
            state_r     <= S_FETCH;
          end else if (fruit_clear) begin
            fruit_valid <= 1'b0;
          end else begin
            fruit_valid <= fruit_valid;
          end
        end

        S_FETCH: begin
          cand_row_r <= fetch_pos_s[8:5];
          cand_col_r <= fetch_pos_s[4:0];
          tries_r    <= tries_r + 6'd1;
          if (fetch_bad_s) begin
            state_r <= S_ADVANCE;
          end else begin
            tmo_r   <= 4'd0;
            occ_req <= 1'b1;
            occ_row <= fetch_pos_s[8:5];
            occ_col <= fetch_pos_s[4:0];
            state_r <= S_QUERY;
          end
        end

        S_QUERY: begin
          // occ_row/occ_col stay put until the query is resolved.
          if (occ_ack) begin
            occ_req <= 1'b0;
            if (occ_hit) begin
              state_r <= S_ADVANCE;
            end else begin
              state_r <= S_COMMIT;
            end
          end else if (tmo_r == TMO_LAST) begin
            // A silent checker is treated as "occupied" so the walk keeps moving.
            occ_req <= 1'b0;
            state_r <= S_ADVANCE;
          end else begin
            tmo_r <= tmo_r + 4'd1;
          end
        end

        S_ADVANCE: begin
          fruit_addr <= addr_inc_s;
          if (tries_r == TRIES_MAX) begin
            state_r <= S_FAIL;
          end else begin
            state_r <= S_FETCH;
          end
        end

        S_COMMIT: begin
          fruit_row   <= cand_row_r;
          fruit_col   <= cand_col_r;
          fruit_valid <= 1'b1;
          spawn_done  <= 1'b1;
          // Step past the committed entry so the next spawn starts fresh.
          fruit_addr  <= addr_inc_s;
          busy        <= 1'b0;
          state_r     <= S_IDLE;
        end

        S_FAIL: begin
          // A full lap has already brought fruit_addr back to its start value.
          spawn_fail <= 1'b1;
          spawn_done <= 1'b1;
          busy       <= 1'b0;
          state_r    <= S_IDLE;
        end

        default: begin
          occ_req <= 1'b0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fruit_spawn_ctrl.sv
// Directed bench for fruit_spawn_ctrl with a small fruit table and a
// scriptable occupancy checker (ack on/off, free-address selection).
module tb_fruit_spawn_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spawn_req = 1'b0;
  logic        fruit_clear = 1'b0;
  logic        occ_ack = 1'b0;
  logic        occ_hit = 1'b0;
  logic        tbl_rst;
  logic [4:0]  fruit_addr;
  logic [31:0] fruit_next;
  logic        occ_req;
  logic [3:0]  occ_row;
  logic [4:0]  occ_col;
  logic        busy;
  logic        fruit_valid;
  logic [3:0]  fruit_row;
  logic [4:0]  fruit_col;
  logic        spawn_done;
  logic        spawn_fail;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tbl [0:30];

  // checker control and handshake log
  bit          ack_en   = 1'b0;
  bit          free_any = 1'b1;
  logic [4:0]  free_addr = 5'd0;
  int          hs_count = 0;
  logic [3:0]  hs_first_row = 4'd0;
  logic [4:0]  hs_first_col = 5'd0;
  logic [3:0]  hs_last_row = 4'd0;
  logic [4:0]  hs_last_col = 5'd0;

  fruit_spawn_ctrl dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .fruit_clear(fruit_clear),
    .tbl_rst(tbl_rst), .fruit_addr(fruit_addr), .fruit_next(fruit_next),
    .occ_req(occ_req), .occ_row(occ_row), .occ_col(occ_col),
    .occ_ack(occ_ack), .occ_hit(occ_hit), .busy(busy),
    .fruit_valid(fruit_valid), .fruit_row(fruit_row), .fruit_col(fruit_col),
    .spawn_done(spawn_done), .spawn_fail(spawn_fail)
  );

  always #5 clk = ~clk;

  assign fruit_next = (fruit_addr <= 5'd30) ? tbl[fruit_addr] : 32'd0;

  // Occupancy checker: answers at the negedge after a request appears.
  always @(negedge clk) begin
    if (occ_req && ack_en) begin
      occ_ack = 1'b1;
      occ_hit = free_any ? 1'b0 : (fruit_addr != free_addr);
      if (hs_count == 0) begin
        hs_first_row = occ_row;
        hs_first_col = occ_col;
      end
      hs_last_row = occ_row;
      hs_last_col = occ_col;
      hs_count = hs_count + 1;
    end else begin
      occ_ack = 1'b0;
      occ_hit = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (spawn_done) seen = 1'b1;
    end
  endtask

  task automatic build_table;
    for (int i = 0; i < 31; i++) begin
      tbl[i] = {18'd0, 1'b0, 4'(i % 15), 5'(i % 21), 4'b0000};
    end
    tbl[0]  = 32'h0000_1910; // row 12 col 17
    tbl[1]  = 32'h0000_1840; // row 12 col 4
    tbl[2]  = 32'h0000_1460; // row 10 col 6
    tbl[3]  = 32'h0000_2000; // pos[9] set -> invalid
    tbl[4]  = 32'h0000_1E00; // row 15 -> invalid
    tbl[5]  = 32'h0000_0150; // col 21 -> invalid
    tbl[6]  = 32'h0000_0A30; // row 5 col 3
    tbl[7]  = 32'h0000_1D40; // row 14 col 20 (corner, valid)
    tbl[30] = 32'h0000_1910; // row 12 col 17
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (tbl_rst !== 1'b1) begin n_fail++; $display("FAIL reset_tbl_rst: got %0b want 1", tbl_rst); end
    n_checks++; if ({busy, occ_req, fruit_valid, spawn_done, spawn_fail} !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, occ_req, fruit_valid, spawn_done, spawn_fail}); end
    n_checks++; if ({fruit_addr, fruit_row, fruit_col} !== 14'd0) begin n_fail++; $display("FAIL reset_regs: got addr=%0d row=%0d col=%0d want 0/0/0", fruit_addr, fruit_row, fruit_col); end
    rst = 1'b1;
    tick();
    n_checks++; if (tbl_rst !== 1'b0) begin n_fail++; $display("FAIL release_tbl_rst: got %0b want 0", tbl_rst); end
  endtask

  task automatic test_first_spawn;
    ack_en = 1'b1; free_any = 1'b1; hs_count = 0;
    do_spawn();
    n_checks++; if ({busy, fruit_valid} !== 2'b10) begin n_fail++; $display("FAIL first_k: busy/valid got %b want 10", {busy, fruit_valid}); end
    tick();
    n_checks++; if ({occ_req, occ_row, occ_col} !== {1'b1, 4'd12, 5'd17}) begin n_fail++; $display("FAIL first_query: got req=%0b row=%0d col=%0d want 1/12/17", occ_req, occ_row, occ_col); end
    tick();
    n_checks++; if ({fruit_valid, spawn_done, occ_req} !== 3'b000) begin n_fail++; $display("FAIL first_commit_cycle: got %b want 000", {fruit_valid, spawn_done, occ_req}); end
    tick();
    n_checks++; if ({fruit_valid, spawn_done, busy} !== 3'b110) begin n_fail++; $display("FAIL first_done: valid/done/busy got %b want 110", {fruit_valid, spawn_done, busy}); end
    n_checks++; if ({fruit_row, fruit_col, fruit_addr} !== {4'd12, 5'd17, 5'd1}) begin n_fail++; $display("FAIL first_pos: got row=%0d col=%0d addr=%0d want 12/17/1", fruit_row, fruit_col, fruit_addr); end
    tick();
    n_checks++; if ({spawn_done, fruit_valid} !== 2'b01) begin n_fail++; $display("FAIL first_pulse_width: done/valid got %b want 01", {spawn_done, fruit_valid}); end
  endtask

  task automatic test_occupied_skip;
    int cyc; bit seen;
    free_any = 1'b0; free_addr = 5'd2; hs_count = 0;
    do_spawn();
    wait_done(50, cyc, seen);
    n_checks++; if (seen !== 1'b1 || cyc != 6) begin n_fail++; $display("FAIL skip_latency: seen=%0b cycles=%0d want 1/6", seen, cyc); end
    n_checks++; if (hs_count != 2 || hs_first_row !== 4'd12 || hs_first_col !== 5'd4) begin n_fail++; $display("FAIL skip_first_query: hs=%0d row=%0d col=%0d want 2/12/4", hs_count, hs_first_row, hs_first_col); end
    n_checks++; if (hs_last_row !== 4'd10 || hs_last_col !== 5'd6) begin n_fail++; $display("FAIL skip_second_query: row=%0d col=%0d want 10/6", hs_last_row, hs_last_col); end
    n_checks++; if ({fruit_valid, fruit_row, fruit_col, fruit_addr} !== {1'b1, 4'd10, 5'd6, 5'd3}) begin n_fail++; $display("FAIL skip_commit: valid=%0b row=%0d col=%0d addr=%0d want 1/10/6/3", fruit_valid, fruit_row, fruit_col, fruit_addr); end
  endtask

  task automatic test_decode_boundary;
    int cyc; bit seen;
    free_any = 1'b0; free_addr = 5'd7; hs_count = 0;
    do_spawn();
    wait_done(80, cyc, seen);
    n_checks++; if (seen !== 1'b1 || cyc != 12) begin n_fail++; $display("FAIL decode_latency: seen=%0b cycles=%0d want 1/12", seen, cyc); end
    n_checks++; if (hs_count != 2 || hs_first_row !== 4'd5 || hs_first_col !== 5'd3) begin n_fail++; $display("FAIL decode_skip_invalid: hs=%0d first row=%0d col=%0d want 2/5/3", hs_count, hs_first_row, hs_first_col); end
    n_checks++; if ({fruit_row, fruit_col, fruit_addr} !== {4'd14, 5'd20, 5'd8}) begin n_fail++; $display("FAIL decode_corner: row=%0d col=%0d addr=%0d want 14/20/8", fruit_row, fruit_col, fruit_addr); end
  endtask

  task automatic test_wrap;
    int cyc; bit seen;
    free_any = 1'b0; free_addr = 5'd29; hs_count = 0;
    do_spawn();
    wait_done(200, cyc, seen);
    n_checks++; if (seen !== 1'b1 || {fruit_row, fruit_col, fruit_addr} !== {4'd14, 5'd8, 5'd30}) begin n_fail++; $display("FAIL wrap_setup: seen=%0b row=%0d col=%0d addr=%0d want 1/14/8/30", seen, fruit_row, fruit_col, fruit_addr); end
    free_addr = 5'd0; hs_count = 0;
    do_spawn();
    wait_done(50, cyc, seen);
    n_checks++; if (seen !== 1'b1 || hs_count != 2 || hs_first_row !== 4'd12 || hs_first_col !== 5'd17) begin n_fail++; $display("FAIL wrap_query: seen=%0b hs=%0d row=%0d col=%0d want 1/2/12/17", seen, hs_count, hs_first_row, hs_first_col); end
    n_checks++; if ({fruit_row, fruit_col, fruit_addr} !== {4'd12, 5'd17, 5'd1}) begin n_fail++; $display("FAIL wrap_commit: row=%0d col=%0d addr=%0d want 12/17/1", fruit_row, fruit_col, fruit_addr); end
  endtask

  task automatic test_total_fail;
    int cyc; bit seen;
    free_any = 1'b0; free_addr = 5'd31; hs_count = 0;
    do_spawn();
    wait_done(400, cyc, seen);
    // 28 valid entries x 3 cycles + 3 invalid x 2 + FAIL
    n_checks++; if (seen !== 1'b1 || cyc != 91) begin n_fail++; $display("FAIL fail_latency: seen=%0b cycles=%0d want 1/91", seen, cyc); end
    n_checks++; if (hs_count != 28) begin n_fail++; $display("FAIL fail_handshakes: got %0d want 28", hs_count); end
    n_checks++; if ({spawn_fail, fruit_valid, fruit_addr} !== {1'b1, 1'b0, 5'd1}) begin n_fail++; $display("FAIL fail_state: fail=%0b valid=%0b addr=%0d want 1/0/1", spawn_fail, fruit_valid, fruit_addr); end
    tick();
    n_checks++; if ({spawn_done, spawn_fail} !== 2'b01) begin n_fail++; $display("FAIL fail_pulse: done/fail got %b want 01", {spawn_done, spawn_fail}); end
    free_any = 1'b1;
    do_spawn();
    n_checks++; if ({spawn_fail, busy} !== 2'b01) begin n_fail++; $display("FAIL fail_cleared: fail/busy got %b want 01", {spawn_fail, busy}); end
    wait_done(50, cyc, seen);
    n_checks++; if (seen !== 1'b1 || {fruit_row, fruit_col, fruit_addr} !== {4'd12, 5'd4, 5'd2}) begin n_fail++; $display("FAIL fail_recover: seen=%0b row=%0d col=%0d addr=%0d want 1/12/4/2", seen, fruit_row, fruit_col, fruit_addr); end
  endtask

  task automatic test_timeout_ignore;
    int cyc; bit seen; int run; int first_run; int extra;
    ack_en = 1'b0; free_any = 1'b0; hs_count = 0;
    cyc = 0; seen = 1'b0; run = 0; first_run = -1; extra = 0;
    do_spawn();
    while (!seen && cyc < 2000) begin
      spawn_req   = busy && (cyc % 5 == 2);
      fruit_clear = busy && (cyc % 7 == 3);
      tick();
      cyc++;
      if (occ_req) run++;
      else if (run > 0 && first_run < 0) first_run = run;
      if (spawn_done) seen = 1'b1;
    end
    spawn_req = 1'b0; fruit_clear = 1'b0;
    // 28 valid x (FETCH + 15 QUERY + ADVANCE) + 3 invalid x 2 + FAIL
    n_checks++; if (seen !== 1'b1 || cyc != 483) begin n_fail++; $display("FAIL tmo_latency: seen=%0b cycles=%0d want 1/483", seen, cyc); end
    n_checks++; if (first_run != 15) begin n_fail++; $display("FAIL tmo_query_len: got %0d want 15", first_run); end
    n_checks++; if (hs_count != 0 || {spawn_fail, fruit_valid, fruit_addr} !== {1'b1, 1'b0, 5'd2}) begin n_fail++; $display("FAIL tmo_result: hs=%0d fail=%0b valid=%0b addr=%0d want 0/1/0/2", hs_count, spawn_fail, fruit_valid, fruit_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (spawn_done || busy) extra++;
    end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL tmo_no_queue: got %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_clear_and_reset;
    int cyc; bit seen; int dones;
    ack_en = 1'b1; free_any = 1'b1;
    do_spawn();
    wait_done(50, cyc, seen);
    n_checks++; if (seen !== 1'b1 || {fruit_valid, fruit_row, fruit_col, fruit_addr} !== {1'b1, 4'd10, 5'd6, 5'd3}) begin n_fail++; $display("FAIL clr_setup: seen=%0b valid=%0b row=%0d col=%0d addr=%0d want 1/1/10/6/3", seen, fruit_valid, fruit_row, fruit_col, fruit_addr); end
    tick();
    fruit_clear = 1'b1;
    tick();
    fruit_clear = 1'b0;
    n_checks++; if ({fruit_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL clr_idle: valid/busy got %b want 00", {fruit_valid, busy}); end
    spawn_req = 1'b1; fruit_clear = 1'b1;
    tick();
    spawn_req = 1'b0; fruit_clear = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_spawn_wins: busy got %0b want 1", busy); end
    wait_done(50, cyc, seen);
    n_checks++; if (seen !== 1'b1 || {fruit_row, fruit_col, fruit_addr} !== {4'd5, 5'd3, 5'd7}) begin n_fail++; $display("FAIL clr_spawn_commit: seen=%0b row=%0d col=%0d addr=%0d want 1/5/3/7", seen, fruit_row, fruit_col, fruit_addr); end
    ack_en = 1'b0;
    do_spawn();
    cyc = 0;
    while (!occ_req && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++; if (occ_req !== 1'b1) begin n_fail++; $display("FAIL midrst_query: occ_req got %0b want 1", occ_req); end
    rst = 1'b0;
    tick();
    n_checks++; if ({occ_req, busy, spawn_done, fruit_valid, tbl_rst} !== 5'b00001 || fruit_addr !== 5'd0) begin n_fail++; $display("FAIL midrst_state: req/busy/done/valid/tbl=%b addr=%0d want 00001/0", {occ_req, busy, spawn_done, fruit_valid, tbl_rst}, fruit_addr); end
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spawn_done || busy) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d busy/done cycles want 0", dones); end
  endtask

  initial begin
    build_table();
    test_reset();
    test_first_spawn();
    test_occupied_skip();
    test_decode_boundary();
    test_wrap();
    test_total_fail();
    test_timeout_ignore();
    test_clear_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
